// File: rtl/ws2812_pkg.sv
// Shared constants for the WS2812 refresh path: pixel layout, default timing, sequencer states.
package ws2812_pkg;

  localparam int unsigned PIXEL_W = 24;
  localparam int unsigned COLOR_W = 8;
  localparam int unsigned G_LSB   = 16;
  localparam int unsigned R_LSB   = 8;
  localparam int unsigned B_LSB   = 0;

  localparam int unsigned CLK_HZ               = 50_000_000;
  localparam int unsigned DEFAULT_FRAME_CYCLES = 2_500_000;  // 50 ms
  localparam int unsigned DEFAULT_LATCH_CYCLES = 15_000;     // 300 us

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWaitRd,
    StSend,
    StDrain,
    StLatch
  } seq_state_e;

endpackage

// File: rtl/ws2812_frame_timer.sv
// Free-running frame period counter; tick marks the wrap cycle while enabled.
module ws2812_frame_timer
  import ws2812_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = DEFAULT_FRAME_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int unsigned CntW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wrap;

  assign wrap   = (cnt_q == CntW'(FRAME_CYCLES - 1));
  assign tick_o = enable_i & wrap;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!enable_i || wrap) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ws2812_frame_sequencer.sv
// Walks the pixel store once per frame, feeds the bit serializer, then holds the latch gap.
module ws2812_frame_sequencer
  import ws2812_pkg::*;
#(
  parameter int unsigned NUM_LED      = 8,
  parameter int unsigned FRAME_CYCLES = DEFAULT_FRAME_CYCLES,
  parameter int unsigned LATCH_CYCLES = DEFAULT_LATCH_CYCLES,
  localparam int unsigned IDX_W       = (NUM_LED > 1) ? $clog2(NUM_LED) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic               frame_req_i,
  output logic               pix_rd_o,
  output logic [IDX_W-1:0]   pix_addr_o,
  input  logic [PIXEL_W-1:0] pix_data_i,
  output logic [PIXEL_W-1:0] tx_data_o,
  output logic               tx_valid_o,
  input  logic               tx_ready_i,
  input  logic               tx_busy_i,
  output logic               busy_o,
  output logic               frame_done_o,
  output logic               overrun_o,
  output logic [15:0]        frame_count_o
);

  localparam int unsigned LatW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  seq_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PIXEL_W-1:0] tx_data_q, tx_data_d;
  logic [LatW-1:0]    latch_q, latch_d;
  logic               pending_q, pending_d;
  logic               overrun_q, overrun_d;
  logic               done_q, done_d;
  logic [15:0]        count_q, count_d;

  logic tick, trigger, last_pix, handshake, latch_end;

  ws2812_frame_timer #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .tick_o   (tick)
  );

  assign trigger   = tick | frame_req_i;
  assign last_pix  = (idx_q == IDX_W'(NUM_LED - 1));
  assign handshake = (state_q == StSend) & tx_ready_i;
  assign latch_end = (state_q == StLatch) && (latch_q == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (trigger || pending_q) state_d = StFetch;
      StFetch:  state_d = StWaitRd;
      StWaitRd: state_d = StSend;
      StSend:   if (tx_ready_i) state_d = last_pix ? StDrain : StFetch;
      StDrain:  if (!tx_busy_i) state_d = StLatch;
      StLatch:  if (latch_q == '0) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    pix_rd_o      = (state_q == StFetch);
    pix_addr_o    = idx_q;
    tx_valid_o    = (state_q == StSend);
    tx_data_o     = tx_data_q;
    busy_o        = (state_q != StIdle);
    frame_done_o  = done_q;
    overrun_o     = overrun_q;
    frame_count_o = count_q;
  end

  always_comb begin
    idx_d = idx_q;
    if (handshake) begin
      idx_d = last_pix ? '0 : idx_q + 1'b1;
    end
    tx_data_d = (state_q == StWaitRd) ? pix_data_i : tx_data_q;
    latch_d   = latch_q;
    if ((state_q == StDrain) && !tx_busy_i) begin
      latch_d = LatW'(LATCH_CYCLES - 1);
    end else if ((state_q == StLatch) && (latch_q != '0)) begin
      latch_d = latch_q - 1'b1;
    end
    // IDLE always consumes the queued request; elsewhere a trigger queues one frame.
    pending_d = (state_q == StIdle) ? 1'b0 : (pending_q | trigger);
    overrun_d = trigger & pending_q;
    done_d    = latch_end;
    count_d   = latch_end ? count_q + 16'd1 : count_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q     <= '0;
      tx_data_q <= '0;
      latch_q   <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      idx_q     <= idx_d;
      tx_data_q <= tx_data_d;
      latch_q   <= latch_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      done_q    <= done_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Bench for ws2812_frame_sequencer: cycle table, directed corner sequences, randomized scoreboard.
module tb_ws2812_frame_sequencer;

  localparam int NL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable = 1'b0;
  logic        frame_req = 1'b0;
  logic        pix_rd;
  logic [1:0]  pix_addr;
  logic [23:0] pix_data = '0;
  logic [23:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        tx_busy = 1'b0;
  logic        busy;
  logic        frame_done;
  logic        overrun;
  logic [15:0] frame_count;

  logic [23:0] mem [NL];
  int total = 0;
  int bad = 0;
  int exp_frames = 0;

  ws2812_frame_sequencer #(
    .NUM_LED      (NL),
    .FRAME_CYCLES (200),
    .LATCH_CYCLES (10)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (enable),
    .frame_req_i   (frame_req),
    .pix_rd_o      (pix_rd),
    .pix_addr_o    (pix_addr),
    .pix_data_i    (pix_data),
    .tx_data_o     (tx_data),
    .tx_valid_o    (tx_valid),
    .tx_ready_i    (tx_ready),
    .tx_busy_i     (tx_busy),
    .busy_o        (busy),
    .frame_done_o  (frame_done),
    .overrun_o     (overrun),
    .frame_count_o (frame_count)
  );

  always #5 clk = ~clk;

  // Pixel store model: data valid one cycle after the read strobe.
  always @(posedge clk) if (pix_rd) pix_data <= mem[pix_addr];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    frame_req = 1'b0;
    enable = 1'b0;
    tx_ready = 1'b1;
    tx_busy = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    rst = 1'b0;
    cyc();
    exp_frames = 0;
  endtask

  typedef struct {
    int          cyc;
    logic        rd;
    logic [1:0]  addr;
    logic        vld;
    logic [23:0] data;
    logic        busy;
    logic        done;
    logic [15:0] cnt;
  } vec_t;

  // One frame with optional stall on the second word and tx_busy held after the last handshake.
  task automatic run_frame(input int stall_len, input int busy_len);
    int hs, stalls, h, done_at, cur;
    hs = 0; stalls = 0; h = -1; done_at = -1;
    frame_req = 1'b1;
    cyc();
    frame_req = 1'b0;
    cur = 1;
    for (int k = 0; k < 400 && done_at < 0; k++) begin
      tx_ready = !(hs == 1 && stalls < stall_len);
      tx_busy  = (h >= 0 && cur > h && cur <= h + busy_len);
      if (tx_valid && tx_ready) begin
        if (hs < NL) chk($sformatf("word%0d", hs), tx_data, mem[hs]);
        hs++;
        if (hs == NL) h = cur;
      end else if (tx_valid) begin
        chk("stall hold data", tx_data, mem[1]);
        stalls++;
      end
      if (h >= 0 && cur == h + busy_len + 11) chk("latch busy/valid", {busy, tx_valid}, 2'b10);
      if (frame_done) done_at = cur;
      cyc();
      cur++;
    end
    tx_ready = 1'b1;
    tx_busy = 1'b0;
    exp_frames++;
    chk("handshakes", hs, NL);
    chk("stall cycles", stalls, stall_len);
    chk("done cycle", done_at, h + busy_len + 12);
    chk("frame_count", frame_count, exp_frames);
  endtask

  initial begin
    vec_t vt[$];
    int cur;
    int starts[$];
    int dones[$];
    int ovr;
    int hs_tot, rd_tot, nst, ndone, novr, trigs;
    bit prev_stall;
    logic [23:0] prev_data;

    mem[0] = 24'h00FF00; mem[1] = 24'hFF0000; mem[2] = 24'h0000FF; mem[3] = 24'h123456;

    rst = 1'b1;
    repeat (2) cyc();
    chk("reset outputs", {pix_rd, pix_addr, tx_valid, tx_data, busy, frame_done, overrun,
                          frame_count}, '0);
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // Manual frame timing table, frame_req in cycle 0.
    vt.push_back('{0,  1'b0, 2'd0, 1'b0, 24'h0,      1'b0, 1'b0, 16'd0});
    vt.push_back('{1,  1'b1, 2'd0, 1'b0, 24'h0,      1'b1, 1'b0, 16'd0});
    vt.push_back('{2,  1'b0, 2'd0, 1'b0, 24'h0,      1'b1, 1'b0, 16'd0});
    vt.push_back('{3,  1'b0, 2'd0, 1'b1, 24'h00FF00, 1'b1, 1'b0, 16'd0});
    vt.push_back('{4,  1'b1, 2'd1, 1'b0, 24'h0,      1'b1, 1'b0, 16'd0});
    vt.push_back('{6,  1'b0, 2'd0, 1'b1, 24'hFF0000, 1'b1, 1'b0, 16'd0});
    vt.push_back('{7,  1'b1, 2'd2, 1'b0, 24'h0,      1'b1, 1'b0, 16'd0});
    vt.push_back('{9,  1'b0, 2'd0, 1'b1, 24'h0000FF, 1'b1, 1'b0, 16'd0});
    vt.push_back('{10, 1'b1, 2'd3, 1'b0, 24'h0,      1'b1, 1'b0, 16'd0});
    vt.push_back('{12, 1'b0, 2'd0, 1'b1, 24'h123456, 1'b1, 1'b0, 16'd0});
    vt.push_back('{13, 1'b0, 2'd0, 1'b0, 24'h0,      1'b1, 1'b0, 16'd0});
    vt.push_back('{14, 1'b0, 2'd0, 1'b0, 24'h0,      1'b1, 1'b0, 16'd0});
    vt.push_back('{23, 1'b0, 2'd0, 1'b0, 24'h0,      1'b1, 1'b0, 16'd0});
    vt.push_back('{24, 1'b0, 2'd0, 1'b0, 24'h0,      1'b0, 1'b1, 16'd1});
    vt.push_back('{25, 1'b0, 2'd0, 1'b0, 24'h0,      1'b0, 1'b0, 16'd1});
    cur = 0;
    frame_req = 1'b1;
    for (int i = 0; i < vt.size(); i++) begin
      while (cur < vt[i].cyc) begin
        cyc();
        cur++;
        frame_req = 1'b0;
      end
      chk($sformatf("table c%0d", vt[i].cyc),
          {pix_rd, pix_rd ? pix_addr : 2'd0, tx_valid, tx_valid ? tx_data : 24'h0,
           busy, frame_done, frame_count},
          {vt[i].rd, vt[i].rd ? vt[i].addr : 2'd0, vt[i].vld, vt[i].vld ? vt[i].data : 24'h0,
           vt[i].busy, vt[i].done, vt[i].cnt});
    end
    exp_frames = 1;
    repeat (3) cyc();

    run_frame(5, 0);
    repeat (3) cyc();
    run_frame(0, 30);
    repeat (3) cyc();

    // Periodic ticks; enable dropped inside the third frame.
    enable = 1'b1;
    starts.delete(); dones.delete();
    for (int c = 0; c < 1200; c++) begin
      if (c == 610) enable = 1'b0;
      if (pix_rd && pix_addr == 2'd0) starts.push_back(c);
      if (frame_done) dones.push_back(c);
      cyc();
    end
    exp_frames += 3;
    chk("tick starts", starts.size(), 3);
    for (int i = 0; i < 3; i++) if (i < starts.size()) chk("tick start cycle", starts[i], 200 * (i + 1));
    chk("tick dones", dones.size(), 3);
    chk("tick frame_count", frame_count, exp_frames);

    // Queue and overrun: extra requests at cycles 5 and 8.
    starts.delete(); dones.delete(); ovr = 0;
    for (int c = 0; c < 120; c++) begin
      frame_req = (c == 0 || c == 5 || c == 8);
      if (pix_rd && pix_addr == 2'd0) starts.push_back(c);
      if (frame_done) dones.push_back(c);
      if (overrun) ovr++;
      cyc();
    end
    frame_req = 1'b0;
    exp_frames += 2;
    chk("queue starts", starts.size(), 2);
    if (starts.size() > 1) chk("queued start cycle", starts[1], 25);
    chk("overrun pulses", ovr, 1);
    chk("queue dones", dones.size(), 2);
    if (dones.size() > 1) chk("queued done cycle", dones[1], 48);
    chk("queue frame_count", frame_count, exp_frames);

    // Reset mid-frame while stalled in SEND.
    tx_ready = 1'b0;
    frame_req = 1'b1;
    cyc();
    frame_req = 1'b0;
    repeat (4) cyc();
    chk("pre-reset in SEND", tx_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async reset outputs", {tx_valid, busy, frame_count, pix_rd, frame_done}, '0);
    @(negedge clk);
    rst = 1'b0;
    tx_ready = 1'b1;
    exp_frames = 0;
    ovr = 0;
    for (int c = 0; c < 300; c++) begin
      if (pix_rd || busy) ovr++;
      cyc();
    end
    chk("idle after reset", ovr, 0);

    // Randomized traffic against a transaction-level scoreboard.
    do_reset();
    for (int i = 0; i < NL; i++) mem[i] = 24'($urandom);
    hs_tot = 0; rd_tot = 0; nst = 0; ndone = 0; novr = 0; trigs = 0;
    prev_stall = 1'b0; prev_data = '0;
    for (int c = 0; c < 4000; c++) begin
      frame_req = (c < 3500) && ($urandom_range(0, 24) == 0);
      if (frame_req) trigs++;
      tx_ready = ($urandom_range(0, 9) < 7);
      tx_busy  = ($urandom_range(0, 3) == 0);
      if (prev_stall) chk("rnd hold", {tx_valid, tx_data}, {1'b1, prev_data});
      if (pix_rd) begin
        chk("rnd addr", pix_addr, rd_tot % NL);
        if (rd_tot % NL == 0) nst++;
        rd_tot++;
      end
      if (tx_valid && tx_ready) begin
        chk("rnd word", tx_data, mem[hs_tot % NL]);
        hs_tot++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (frame_done) ndone++;
      if (overrun) novr++;
      cyc();
    end
    tx_ready = 1'b1;
    tx_busy = 1'b0;
    chk("rnd idle at end", busy, 1'b0);
    chk("rnd starts=dones", nst, ndone);
    chk("rnd frame_count", frame_count, ndone);
    chk("rnd trigger conservation", trigs, nst + novr);
    chk("rnd handshakes", hs_tot, nst * NL);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ws2812_frame_sequencer.md
Name: ws2812_frame_sequencer

Overview:
Sequences one refresh of a WS2812 strip. It reads GRB pixel words from a pixel store, one per LED. It hands them to the bit serializer over a valid/ready handshake, waits for the serializer to drain, then holds the line idle for the latch/reset gap. Frames start on an internal periodic frame tick or on a manual request. The block sits between the pattern generator's pixel store and the ws2812 bit driver.

Parameters:
- NUM_LED, 8: number of LEDs in the chain; must be >= 1.
- FRAME_CYCLES, 2_500_000: frame period in clk cycles (50 ms at 50 MHz); must be >= 1.
- LATCH_CYCLES, 15_000: latch gap in clk cycles after the last bit (300 us at 50 MHz); must be >= 1.
- IDX_W, $clog2(NUM_LED) (min 1): derived pixel index width; local, not overridable.

Ports:
- clk, in, 1: system clock, 50 MHz.
- rst, in, 1: asynchronous, active-high reset.
- enable, in, 1: enables the periodic frame tick.
- frame_req, in, 1: one-cycle manual refresh request.
- pix_rd, out, 1: pixel store read strobe.
- pix_addr, out, IDX_W: pixel index being read.
- pix_data, in, 24: GRB word; valid exactly 1 cycle after pix_rd.
- tx_data, out, 24: GRB word to the serializer.
- tx_valid, out, 1: tx_data valid.
- tx_ready, in, 1: serializer accepts a word.
- tx_busy, in, 1: serializer is still shifting bits.
- busy, out, 1: a frame is in progress (state != IDLE).
- frame_done, out, 1: one-cycle pulse at the end of the latch gap.
- overrun, out, 1: one-cycle pulse when a trigger is dropped.
- frame_count, out, 16: completed frames; wraps 65535 -> 0.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE, pixel index 0, pending 0, frame timer 0.
  - Reset is honoured mid-frame: tx_valid drops immediately. The serializer shares rst.
- Frame timer:
  - Counts 0..FRAME_CYCLES-1 while enable=1 and asserts tick on the wrap cycle.
  - enable=0 clears the counter to 0 and suppresses tick.
  - A frame already in progress always completes regardless of enable.
- Trigger:
  - trigger = tick | frame_req.
  - In IDLE, a trigger or pending=1 moves the FSM to FETCH on the next edge and clears pending.
  - Outside IDLE, a trigger sets pending.
  - A trigger while pending=1 is already set pulses overrun for 1 cycle and is dropped; at most one queued frame.
  - tick and frame_req in the same cycle count as one trigger.
- FSM states:
  - IDLE: wait for a trigger as above.
  - FETCH: pix_rd=1, pix_addr=idx (registered outputs), 1 cycle, then WAIT_RD.
  - WAIT_RD: capture pix_data into tx_data, 1 cycle, then SEND.
  - SEND: tx_valid=1; tx_data is held stable until tx_valid&tx_ready. On that handshake:
    - if idx==NUM_LED-1: clear idx, go to DRAIN;
    - else idx+1, go to FETCH.
    - tx_valid is low in every other state.
  - DRAIN: wait while tx_busy=1. When tx_busy=0, load the latch counter and go to LATCH.
  - LATCH: stays exactly LATCH_CYCLES cycles with tx_valid=0. Then go to IDLE; in that IDLE-entry cycle frame_done=1 and frame_count increments.
- Throughput and latency:
  - Minimum 3 cycles per pixel (FETCH, WAIT_RD, SEND with tx_ready=1).
  - A trigger in IDLE at cycle t gives pix_rd at t+1 and tx_valid at t+3.
- Edge cases:
  - NUM_LED=1: the single handshake goes straight to DRAIN.
  - tx_ready held low stalls SEND indefinitely; no timeout.
  - A pending frame starts in the same IDLE cycle in which frame_done pulses.

Decomposition:
- Package ws2812_pkg:
  - PIXEL_W=24.
  - GRB field offsets: G[23:16], R[15:8], B[7:0].
  - Default timing constants (CLK_HZ, FRAME_CYCLES, LATCH_CYCLES).
  - FSM state encoding constants.
- Sub-module ws2812_frame_timer: parameter FRAME_CYCLES; inputs clk, rst, enable; output tick.

Test Plan:
Common setup: NUM_LED=4, FRAME_CYCLES=200, LATCH_CYCLES=10, pixel store 0x00FF00, 0xFF0000, 0x0000FF, 0x123456, tx_busy=0 unless stated.
- Manual frame, tx_ready=1: frame_req at cycle 0 ->
  - pix_addr 0..3 at cycles 1, 4, 7, 10;
  - tx_valid at 3, 6, 9, 12 with words in store order;
  - DRAIN at 13, LATCH 14-23;
  - frame_done and frame_count=1 at cycle 24.
- Back-pressure: tx_ready=0 for 5 cycles at the second word -> tx_data stays 0xFF0000 and tx_valid stays 1 throughout the stall; exactly 4 handshakes occur.
- Drain: tx_busy held 1 for 30 cycles after the last handshake -> LATCH starts the cycle after tx_busy falls; frame_done comes 10 cycles later.
- Periodic ticks and enable: enable=1 -> a frame starts every 200 cycles. Drop enable mid-frame -> that frame completes and no further frames start.
- Queue and overrun: two frame_req pulses during one frame ->
  - first sets pending;
  - second pulses overrun once;
  - exactly one extra frame starts at frame_done.
- Reset mid-frame: assert rst during SEND -> tx_valid, busy and frame_count go to 0 immediately. After release, no frame starts without a trigger.
